ex_stage: RTL and testbench

Execute stage of the 5-stage RV32I pipeline. Holds the ID/EX pipeline register, resolves operand forwarding from MEM and WB, and executes the 3-bit ALU operation produced by the decode-side ALU decoder. It resolves branches and jumps, and registers results into the EX/MEM pipeline register consumed by the memory stage.

---
 rtl/ex_stage.sv | 196 +++++++++++++++++++
 tb/tb_ex_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: ID/EX register, MEM/WB operand forwarding,
// ALU, branch/jump resolution and the EX/MEM register feeding the memory stage.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            d_valid,
  input  logic            d_regwrite,
  input  logic            d_memwrite,
  input  logic            d_branch,
  input  logic            d_jump,
  input  logic            d_alusrc,
  input  logic [1:0]      d_resultsrc,
  input  logic [2:0]      d_alucontrol,
  input  logic [XLEN-1:0] d_rd1,
  input  logic [XLEN-1:0] d_rd2,
  input  logic [XLEN-1:0] d_imm,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_pcplus4,
  input  logic [4:0]      d_rs1,
  input  logic [4:0]      d_rs2,
  input  logic [4:0]      d_rd,
  input  logic            w_regwrite,
  input  logic [4:0]      w_rd,
  input  logic [XLEN-1:0] w_result,
  output logic [4:0]      e_rs1,
  output logic [4:0]      e_rs2,
  output logic [4:0]      e_rd,
  output logic            e_load,
  output logic            pcsrc_e,
  output logic [XLEN-1:0] pctarget_e,
  output logic            m_valid,
  output logic            m_regwrite,
  output logic            m_memwrite,
  output logic [1:0]      m_resultsrc,
  output logic [4:0]      m_rd,
  output logic [XLEN-1:0] m_aluresult,
  output logic [XLEN-1:0] m_writedata,
  output logic [XLEN-1:0] m_pcplus4
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic            e_valid;
  logic            e_regwrite;
  logic            e_memwrite;
  logic            e_branch;
  logic            e_jump;
  logic            e_alusrc;
  logic [1:0]      e_resultsrc;
  logic [2:0]      e_alucontrol;
  logic [XLEN-1:0] e_rd1;
  logic [XLEN-1:0] e_rd2;
  logic [XLEN-1:0] e_imm;
  logic [XLEN-1:0] e_pc;
  logic [XLEN-1:0] e_pcplus4;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Operand select: the older in-flight producer (WB) loses to the younger one (MEM).
  function automatic logic [XLEN-1:0] forward(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] regval,
    input logic            mem_wr,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_val,
    input logic            wb_wr,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] sel;
    sel = regval;
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = mem_val;
    end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = wb_val;
    end
    return sel;
  endfunction

  function automatic logic [XLEN-1:0] alu(
    input logic [2:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [XLEN-1:0]        res;
    sa  = a;
    sb  = b;
    res = '0;
    case (op)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLL: res = a << b[4:0];
      ALU_SRL: res = a >> b[4:0];
      default: res = '0;
    endcase
    return res;
  endfunction

  // ID/EX register
  always_ff @(posedge clk) begin
    if (!reset_n || flush_e) begin
      e_valid      <= 1'b0;
      e_regwrite   <= 1'b0;
      e_memwrite   <= 1'b0;
      e_branch     <= 1'b0;
      e_jump       <= 1'b0;
      e_alusrc     <= 1'b0;
      e_resultsrc  <= 2'b00;
      e_alucontrol <= 3'b000;
      e_rd1        <= '0;
      e_rd2        <= '0;
      e_imm        <= '0;
      e_pc         <= '0;
      e_pcplus4    <= '0;
      e_rs1        <= 5'd0;
      e_rs2        <= 5'd0;
      e_rd         <= 5'd0;
    end else if (!stall_e) begin
      e_valid      <= d_valid;
      e_regwrite   <= d_regwrite;
      e_memwrite   <= d_memwrite;
      e_branch     <= d_branch;
      e_jump       <= d_jump;
      e_alusrc     <= d_alusrc;
      e_resultsrc  <= d_resultsrc;
      e_alucontrol <= d_alucontrol;
      e_rd1        <= d_rd1;
      e_rd2        <= d_rd2;
      e_imm        <= d_imm;
      e_pc         <= d_pc;
      e_pcplus4    <= d_pcplus4;
      e_rs1        <= d_rs1;
      e_rs2        <= d_rs2;
      e_rd         <= d_rd;
    end
  end

  // Execute: forwarding, ALU, branch resolution
  always_comb begin
    src_a      = forward(e_rs1, e_rd1, m_valid & m_regwrite, m_rd, m_aluresult,
                         w_regwrite, w_rd, w_result);
    fwd_b      = forward(e_rs2, e_rd2, m_valid & m_regwrite, m_rd, m_aluresult,
                         w_regwrite, w_rd, w_result);
    src_b      = e_alusrc ? e_imm : fwd_b;
    alu_result = alu(e_alucontrol, src_a, src_b);
    zero       = (alu_result == '0);
  end

  assign pctarget_e = e_pc + e_imm;
  // A stalled instruction must not redirect; it will resolve once it is released.
  assign pcsrc_e    = reset_n & e_valid & ~stall_e & (e_jump | (e_branch & zero));
  assign e_load     = e_valid & (e_resultsrc == 2'b01);

  // EX/MEM register: a stall in E sends a bubble so the held instruction is not duplicated
  always_ff @(posedge clk) begin
    if (!reset_n || stall_e) begin
      m_valid     <= 1'b0;
      m_regwrite  <= 1'b0;
      m_memwrite  <= 1'b0;
      m_resultsrc <= 2'b00;
      m_rd        <= 5'd0;
      m_aluresult <= '0;
      m_writedata <= '0;
      m_pcplus4   <= '0;
    end else begin
      m_valid     <= e_valid;
      m_regwrite  <= e_valid & e_regwrite;
      m_memwrite  <= e_valid & e_memwrite;
      m_resultsrc <= e_resultsrc;
      m_rd        <= e_rd;
      m_aluresult <= alu_result;
      m_writedata <= fwd_b;
      m_pcplus4   <= e_pcplus4;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: reset, ALU sweep, forwarding, branches,
// stall and flush behaviour, with hand-computed expected values.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_e, flush_e;
  logic        d_valid, d_regwrite, d_memwrite, d_branch, d_jump, d_alusrc;
  logic [1:0]  d_resultsrc;
  logic [2:0]  d_alucontrol;
  logic [31:0] d_rd1, d_rd2, d_imm, d_pc, d_pcplus4;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        w_regwrite;
  logic [4:0]  w_rd;
  logic [31:0] w_result;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic        e_load, pcsrc_e;
  logic [31:0] pctarget_e;
  logic        m_valid, m_regwrite, m_memwrite;
  logic [1:0]  m_resultsrc;
  logic [4:0]  m_rd;
  logic [31:0] m_aluresult, m_writedata, m_pcplus4;

  int checks = 0;
  int failures = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
    .d_valid(d_valid), .d_regwrite(d_regwrite), .d_memwrite(d_memwrite),
    .d_branch(d_branch), .d_jump(d_jump), .d_alusrc(d_alusrc),
    .d_resultsrc(d_resultsrc), .d_alucontrol(d_alucontrol),
    .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_pc(d_pc), .d_pcplus4(d_pcplus4),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .w_regwrite(w_regwrite), .w_rd(w_rd), .w_result(w_result),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_load(e_load),
    .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e),
    .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memwrite(m_memwrite),
    .m_resultsrc(m_resultsrc), .m_rd(m_rd), .m_aluresult(m_aluresult),
    .m_writedata(m_writedata), .m_pcplus4(m_pcplus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    d_valid = 0; d_regwrite = 0; d_memwrite = 0; d_branch = 0; d_jump = 0;
    d_alusrc = 0; d_resultsrc = 2'b00; d_alucontrol = 3'b000;
    d_rd1 = 0; d_rd2 = 0; d_imm = 0; d_pc = 0; d_pcplus4 = 0;
    d_rs1 = 0; d_rs2 = 0; d_rd = 0;
  endtask

  task automatic alu_instr(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic use_imm, input logic [31:0] imm);
    nop();
    d_valid = 1; d_regwrite = 1; d_alucontrol = op; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
    d_rd1 = rd1; d_rd2 = rd2; d_alusrc = use_imm; d_imm = imm;
  endtask

  logic [2:0]  sweep_op  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111, 3'b100};
  logic [31:0] sweep_exp [8] = '{32'hFFFFFFF4, 32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFF4,
                                 32'h00000001, 32'hFFFFFF00, 32'h0FFFFFFF, 32'h00000000};

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a nonzero load/jump instruction presented
    reset_n = 0; stall_e = 0; flush_e = 0;
    w_regwrite = 0; w_rd = 0; w_result = 0;
    alu_instr(3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b1, 32'h4);
    d_jump = 1; d_resultsrc = 2'b01; d_memwrite = 1; d_pc = 32'h40; d_pcplus4 = 32'h44;
    #2;
    step();
    check("rst_pcsrc_e1", {31'd0, pcsrc_e}, 32'd0);
    step();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_regwrite", {31'd0, m_regwrite}, 32'd0);
    check("rst_m_aluresult", m_aluresult, 32'd0);
    check("rst_m_pcplus4", m_pcplus4, 32'd0);
    check("rst_pcsrc_e", {31'd0, pcsrc_e}, 32'd0);
    check("rst_e_load", {31'd0, e_load}, 32'd0);
    check("rst_e_rd", {27'd0, e_rd}, 32'd0);
    reset_n = 1;

    // Load enters E: e_load visible, result class carried to MEM
    alu_instr(3'b000, 5'd0, 5'd0, 5'd12, 32'h100, 32'h0, 1'b1, 32'h8);
    d_resultsrc = 2'b01; d_pcplus4 = 32'h204;
    step();
    check("load_e_load", {31'd0, e_load}, 32'd1);
    check("load_e_rd", {27'd0, e_rd}, 32'd12);
    nop();
    step();
    check("load_m_resultsrc", {30'd0, m_resultsrc}, 32'd1);
    check("load_m_aluresult", m_aluresult, 32'h108);
    check("load_m_pcplus4", m_pcplus4, 32'h204);
    check("load_m_regwrite", {31'd0, m_regwrite}, 32'd1);

    // ALU sweep on 0xFFFFFFF0 op 4, no forwarding (x0 destination)
    for (int i = 0; i < 8; i++) begin
      alu_instr(sweep_op[i], 5'd1, 5'd2, 5'd0, 32'hFFFFFFF0, 32'h0, 1'b1, 32'h4);
      d_regwrite = 0;
      step();
      step();
      check($sformatf("alu_op%0d", sweep_op[i]), m_aluresult, sweep_exp[i]);
    end

    // Back-to-back dependency through MEM: x5=3+4, then x6=x5+x5
    alu_instr(3'b000, 5'd1, 5'd0, 5'd5, 32'h3, 32'h0, 1'b1, 32'h4);
    step();
    alu_instr(3'b000, 5'd5, 5'd5, 5'd6, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check("fwd_producer", m_aluresult, 32'd7);
    nop();
    step();
    check("fwd_mem_result", m_aluresult, 32'd14);
    check("fwd_mem_writedata", m_writedata, 32'd7);

    // Producer writing x0 is never forwarded
    alu_instr(3'b000, 5'd1, 5'd0, 5'd0, 32'h7, 32'h0, 1'b1, 32'h0);
    step();
    alu_instr(3'b000, 5'd0, 5'd0, 5'd9, 32'h2, 32'h3, 1'b0, 32'h0);
    step();
    nop();
    step();
    check("fwd_x0_blocked", m_aluresult, 32'd5);

    // MEM (x5=9) beats WB (x5=1); later WB alone supplies x5
    w_regwrite = 1; w_rd = 5'd5; w_result = 32'd1;
    alu_instr(3'b000, 5'd1, 5'd0, 5'd5, 32'h9, 32'h0, 1'b1, 32'h0);
    step();
    alu_instr(3'b000, 5'd5, 5'd0, 5'd7, 32'h0, 32'h0, 1'b1, 32'h0);
    step();
    alu_instr(3'b000, 5'd5, 5'd0, 5'd8, 32'h0, 32'h0, 1'b1, 32'h0);
    step();
    check("fwd_mem_over_wb", m_aluresult, 32'd9);
    nop();
    step();
    check("fwd_wb_only", m_aluresult, 32'd1);
    w_regwrite = 0; w_rd = 0; w_result = 0;

    // beq taken / not taken, then jump with unequal operands
    nop();
    d_valid = 1; d_branch = 1; d_alucontrol = 3'b001; d_rs1 = 5'd10; d_rs2 = 5'd11;
    d_rd1 = 32'h55; d_rd2 = 32'h55; d_pc = 32'h100; d_imm = 32'h20;
    step();
    check("beq_taken", {31'd0, pcsrc_e}, 32'd1);
    check("beq_target", pctarget_e, 32'h120);
    d_rd2 = 32'h56;
    step();
    check("beq_not_taken", {31'd0, pcsrc_e}, 32'd0);
    check("branch_no_write", {31'd0, m_regwrite}, 32'd0);
    d_branch = 0; d_jump = 1;
    step();
    check("jump_taken", {31'd0, pcsrc_e}, 32'd1);

    // Stall two cycles, then flush while still stalled
    alu_instr(3'b000, 5'd1, 5'd0, 5'd9, 32'h5, 32'h0, 1'b1, 32'h1);
    d_jump = 1;
    step();
    check("pre_stall_pcsrc", {31'd0, pcsrc_e}, 32'd1);
    stall_e = 1;
    alu_instr(3'b000, 5'd1, 5'd0, 5'd13, 32'h64, 32'h0, 1'b1, 32'h1);
    #1;
    check("stall_pcsrc_comb", {31'd0, pcsrc_e}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("stall%0d_m_valid", i), {31'd0, m_valid}, 32'd0);
      check($sformatf("stall%0d_e_rd", i), {27'd0, e_rd}, 32'd9);
      check($sformatf("stall%0d_pcsrc", i), {31'd0, pcsrc_e}, 32'd0);
    end
    flush_e = 1;
    step();
    check("flush_e_rd", {27'd0, e_rd}, 32'd0);
    check("flush_m_valid", {31'd0, m_valid}, 32'd0);
    flush_e = 0; stall_e = 0;
    nop();
    step();
    check("bubble_m_valid", {31'd0, m_valid}, 32'd0);
    check("bubble_m_regwrite", {31'd0, m_regwrite}, 32'd0);

    // Reset mid-stream clears outputs at the first reset edge
    alu_instr(3'b011, 5'd1, 5'd0, 5'd4, 32'hF0, 32'h0, 1'b1, 32'h0F);
    step();
    step();
    check("mid_pre_reset", m_aluresult, 32'hFF);
    reset_n = 0;
    step();
    check("mid_reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("mid_reset_m_aluresult", m_aluresult, 32'd0);
    reset_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
